// File: rtl/key_debounce.sv
// Debounces a raw asynchronous key level: two-flop synchroniser followed by a
// stability-counter FSM producing a clean level, rise/fall pulses and a press count.
module key_debounce #(
   parameter int unsigned STABLE_CYCLES = 50000,
   parameter int unsigned CNT_W         = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_in,
   output logic       key_level,
   output logic       key_rise,
   output logic       key_fall,
   output logic [7:0] press_cnt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      CHK_HIGH = 2'd1,
      HIGH     = 2'd2,
      CHK_LOW  = 2'd3
   } state_e;

   logic             ff1_q, ff2_q;
   logic             s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             key_level_q, key_level_d;
   logic             key_rise_q, key_rise_d;
   logic             key_fall_q, key_fall_d;
   logic [7:0]       press_cnt_q, press_cnt_d;

   // Two-flop synchroniser; the only sampler of key_in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff1_q <= 1'b0;
         ff2_q <= 1'b0;
      end else begin
         ff1_q <= key_in;
         ff2_q <= ff1_q;
      end
   end

   assign s = ff2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOW;
         cnt_q       <= '0;
         key_level_q <= 1'b0;
         key_rise_q  <= 1'b0;
         key_fall_q  <= 1'b0;
         press_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_level_q <= key_level_d;
         key_rise_q  <= key_rise_d;
         key_fall_q  <= key_fall_d;
         press_cnt_q <= press_cnt_d;
      end
   end

   // Any bounce in a CHK state falls back to the stable state with cnt cleared.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      key_level_d = key_level_q;
      key_rise_d  = 1'b0;
      key_fall_d  = 1'b0;
      press_cnt_d = press_cnt_q;
      case (state_q)
         LOW: begin
            if (s) begin
               state_d = CHK_HIGH;
               cnt_d   = '0;
            end
         end
         CHK_HIGH: begin
            if (!s) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = HIGH;
               cnt_d       = '0;
               key_level_d = 1'b1;
               key_rise_d  = 1'b1;
               press_cnt_d = 8'(press_cnt_q + 8'd1);
            end else begin
               cnt_d = CNT_W'(cnt_q + 1'b1);
            end
         end
         HIGH: begin
            if (!s) begin
               state_d = CHK_LOW;
               cnt_d   = '0;
            end
         end
         CHK_LOW: begin
            if (s) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = LOW;
               cnt_d       = '0;
               key_level_d = 1'b0;
               key_fall_d  = 1'b1;
            end else begin
               cnt_d = CNT_W'(cnt_q + 1'b1);
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
         end
      endcase
   end

   assign key_level = key_level_q;
   assign key_rise  = key_rise_q;
   assign key_fall  = key_fall_q;
   assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected pulses (cycle, kind, press count)
// are queued as key_in is driven and checked when the DUT emits them.
module tb_key_debounce;

   localparam int unsigned STABLE = 4;

   logic       clk;
   logic       rst_n;
   logic       key_in;
   logic       key_level;
   logic       key_rise;
   logic       key_fall;
   logic [7:0] press_cnt;

   typedef struct {
      logic        rise;
      int unsigned at;
      logic [7:0]  press;
   } ev_t;

   ev_t         exp_q[$];
   int unsigned cyc;
   int unsigned n_checks;
   int unsigned n_fail;
   int unsigned n_rise;
   int unsigned n_fall;
   logic [7:0]  exp_press;

   key_debounce #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in),
      .key_level (key_level),
      .key_rise  (key_rise),
      .key_fall  (key_fall),
      .press_cnt (press_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Queue an accept expected 7 negedges after the current one (edge STABLE+2 after capture).
   task automatic expect_ev(input logic rise);
      ev_t e;
      if (rise) exp_press = 8'(exp_press + 8'd1);
      e.rise  = rise;
      e.at    = cyc + STABLE + 3;
      e.press = exp_press;
      exp_q.push_back(e);
   endtask

   task automatic drive_key(input logic val);
      @(negedge clk);
      key_in = val;
      expect_ev(val);
      repeat (10) @(negedge clk);
   endtask

   // Pulse monitor: every pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      if (rst_n && (key_rise || key_fall)) begin
         check_eq("rise_and_fall_exclusive", 32'(key_rise & key_fall), 32'd0);
         if (key_rise) n_rise++;
         if (key_fall) n_fall++;
         if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse", {30'd0, key_rise, key_fall}, 32'd0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check_eq("pulse_kind", 32'(key_rise), 32'(e.rise));
            check_eq("pulse_cycle", cyc, e.at);
            check_eq("pulse_level", 32'(key_level), 32'(e.rise));
            check_eq("pulse_press_cnt", 32'(press_cnt), 32'(e.press));
         end
      end
   end

   initial begin
      int unsigned c;
      int unsigned r0, f0;
      logic        bounce [6];
      cyc       = 0;
      n_checks  = 0;
      n_fail    = 0;
      n_rise    = 0;
      n_fall    = 0;
      exp_press = 8'd0;
      rst_n     = 1'b0;
      key_in    = 1'b0;

      // Held reset with a toggling key.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         key_in = ~key_in;
         check_eq("reset_hold", {28'd0, key_level, key_rise, key_fall, 1'b0} | 32'(press_cnt), 32'd0);
      end
      @(negedge clk);
      key_in = 1'b0;
      rst_n  = 1'b1;
      repeat (4) @(negedge clk);

      // Clean press with explicit edge-by-edge checks around the accept.
      @(negedge clk);
      key_in = 1'b1;
      expect_ev(1'b1);
      repeat (6) @(negedge clk);
      check_eq("clean_before_accept", 32'(key_level), 32'd0);
      @(negedge clk);
      check_eq("clean_level_at_accept", 32'(key_level), 32'd1);
      @(negedge clk);
      check_eq("clean_rise_one_cycle", 32'(key_rise), 32'd0);
      check_eq("clean_press_cnt", 32'(press_cnt), 32'd1);
      repeat (3) @(negedge clk);

      // Release.
      drive_key(1'b0);
      check_eq("release_level", 32'(key_level), 32'd0);
      check_eq("release_press_cnt", 32'(press_cnt), 32'd1);

      // 3-cycle glitch is rejected.
      @(negedge clk);
      key_in = 1'b1;
      repeat (3) @(negedge clk);
      key_in = 1'b0;
      repeat (12) @(negedge clk);
      check_eq("glitch3_level", 32'(key_level), 32'd0);
      check_eq("glitch3_press_cnt", 32'(press_cnt), 32'd1);

      // Shortest accepted pulse: one rise, then one fall.
      @(negedge clk);
      key_in = 1'b1;
      expect_ev(1'b1);
      repeat (5) @(negedge clk);
      key_in = 1'b0;
      expect_ev(1'b0);
      repeat (14) @(negedge clk);
      check_eq("short_pulse_level", 32'(key_level), 32'd0);

      // Bounce then hold high: single rise timed from the final capture.
      bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         key_in = bounce[i];
      end
      expect_ev(1'b1);
      repeat (12) @(negedge clk);
      check_eq("bounce_level", 32'(key_level), 32'd1);
      check_eq("bounce_press_cnt", 32'(press_cnt), 32'd3);
      drive_key(1'b0);

      // Asynchronous reset mid-cycle while HIGH.
      drive_key(1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_eq("async_reset_clear", {23'd0, key_level, key_rise, key_fall, press_cnt}, 32'd0);
      @(negedge clk);
      key_in = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      exp_press = 8'd0;
      repeat (4) @(negedge clk);

      // 256 presses: counter wraps 255 -> 0.
      r0 = n_rise;
      f0 = n_fall;
      for (int i = 1; i <= 256; i++) begin
         drive_key(1'b1);
         if (i == 255) check_eq("wrap_255", 32'(press_cnt), 32'd255);
         if (i == 256) check_eq("wrap_0", 32'(press_cnt), 32'd0);
         drive_key(1'b0);
      end
      check_eq("wrap_rise_count", n_rise - r0, 32'd256);
      check_eq("wrap_fall_count", n_fall - f0, 32'd256);

      // Reset while in CHK_HIGH with cnt=2, key held high through release.
      drive_key(1'b1);
      drive_key(1'b0);
      @(negedge clk);
      key_in = 1'b1;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_eq("chk_reset_clear", {23'd0, key_level, key_rise, key_fall, press_cnt}, 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      exp_press = 8'd0;
      expect_ev(1'b1);
      repeat (10) @(negedge clk);
      check_eq("chk_reset_press_cnt", 32'(press_cnt), 32'd1);
      drive_key(1'b0);

      repeat (5) @(negedge clk);
      c = exp_q.size();
      check_eq("pending_expectations", c, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
